// File: rtl/pulse_burst_gen_pkg.sv
// pulse_burst_gen shared definitions: FSM states, parameter limits,
// defaults, and a small helper for sizing the phase timer.
package pulse_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        GAP,
        DONE
    } state_t;

    // The pulse maker needs a 6-cycle low to finish its countdown
    // and at least one high cycle to re-arm.
    localparam int MIN_LOW_CYCLES = 6;
    localparam int MIN_GAP_CYCLES = 1;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LOW_CYCLES = 6;
    localparam int DEF_GAP_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_burst_gen_phase_timer.sv
// phase_timer: loadable down-counter with a registered expired flag.
// Loading L raises expired after L-1 further edges, i.e. L periods.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Count down from load_val-1; flag the last period of the phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (load) begin
            cnt     <= load_val - W'(1);
            expired <= (load_val <= W'(1));
        end else begin
            if (cnt != '0) begin
                cnt <= cnt - W'(1);
            end
            expired <= (cnt == W'(1));
        end
    end

endmodule

// File: rtl/pulse_burst_gen.sv
// pulse_burst_gen: drives an active-low request through N low/gap phases.
// Optional abort input enabled by defining PULSE_BURST_ABORT_EN.
module pulse_burst_gen
    import pulse_burst_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOW_CYCLES = DEF_LOW_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PULSE_BURST_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             req_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam int TW = $clog2(max_int(LOW_CYCLES, GAP_CYCLES) + 1);

    if (LOW_CYCLES < MIN_LOW_CYCLES) begin : g_low_chk
        $error("LOW_CYCLES too small for the pulse maker");
    end
    if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_gap_chk
        $error("GAP_CYCLES too small for the pulse maker");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] rem_n;
    logic             req_n_n, busy_n, done_n;
    logic             tm_load, tm_exp;
    logic [TW-1:0]    tm_val;
    logic             abort_q;

`ifdef PULSE_BURST_ABORT_EN
    assign abort_q = abort;
`else
    assign abort_q = 1'b0;
`endif

    phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tm_load),
        .load_val (tm_val),
        .expired  (tm_exp)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            req_n     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            req_n     <= req_n_n;
            busy      <= busy_n;
            done      <= done_n;
            remaining <= rem_n;
        end
    end

    // Next state, phase timer loads and next output values.
    always_comb begin
        state_n = state;
        rem_n   = remaining;
        tm_load = 1'b0;
        tm_val  = TW'(LOW_CYCLES);
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        rem_n   = count;
                        tm_load = 1'b1;
                        state_n = LOW;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            LOW: begin
                if (abort_q) begin
                    state_n = DONE;
                end else if (tm_exp) begin
                    if (remaining != '0) begin
                        rem_n = remaining - CNT_W'(1);
                    end
                    if (remaining <= CNT_W'(1)) begin
                        state_n = DONE;
                    end else begin
                        tm_load = 1'b1;
                        tm_val  = TW'(GAP_CYCLES);
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (abort_q) begin
                    state_n = DONE;
                end else if (tm_exp) begin
                    tm_load = 1'b1;
                    state_n = LOW;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        req_n_n = (state_n != LOW);
        busy_n  = (state_n == LOW) || (state_n == GAP);
        done_n  = (state_n == DONE);
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// tb_pulse_burst_gen: directed checks of burst timing, zero count,
// ignored start, mid-burst reset and (if enabled) abort.
module tb_pulse_burst_gen;

    localparam int LOWC = 6;
    localparam int GAPC = 4;
    localparam int PER  = LOWC + GAPC;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic       req_n, busy, done;
    logic [7:0] remaining;
`ifdef PULSE_BURST_ABORT_EN
    logic       abort;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pulse_burst_gen dut (
        .clk       (clk),
        .reset     (reset),
`ifdef PULSE_BURST_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .count     (count),
        .req_n     (req_n),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a burst of n and check every cycle against the phase model.
    // At cycle inj a second start with count 9 is driven (ignored).
    task automatic run_burst(input int n, input int inj);
        int total;
        int exp_rem;
        int exp_req;
        total = n * PER - GAPC;
        start = 1'b1;
        count = n[7:0];
        tick();
        start = 1'b0;
        count = 8'd0;
        for (int i = 0; i < total; i++) begin
            exp_req = ((i % PER) < LOWC) ? 0 : 1;
            exp_rem = n - (i + GAPC) / PER;
            chk("burst_req_n", {31'd0, req_n}, exp_req);
            chk("burst_busy", {31'd0, busy}, 1);
            chk("burst_done", {31'd0, done}, 0);
            chk("burst_remaining", {24'd0, remaining}, exp_rem);
            if (i == inj) begin
                start = 1'b1;
                count = 8'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        count = 8'd0;
        chk("end_done", {31'd0, done}, 1);
        chk("end_busy", {31'd0, busy}, 0);
        chk("end_req_n", {31'd0, req_n}, 1);
        chk("end_remaining", {24'd0, remaining}, 0);
        tick();
        chk("post_done", {31'd0, done}, 0);
        chk("post_req_n", {31'd0, req_n}, 1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b1;
        count = 8'd3;
`ifdef PULSE_BURST_ABORT_EN
        abort = 1'b0;
`endif
        // Reset held 3 cycles with start asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req_n", {31'd0, req_n}, 1);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_done", {31'd0, done}, 0);
            chk("rst_remaining", {24'd0, remaining}, 0);
        end
        start = 1'b0;
        count = 8'd0;
        reset = 1'b1;
        tick();

        // Burst of 3.
        run_burst(3, -1);
        tick();

        // Zero count.
        start = 1'b1;
        count = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_busy", {31'd0, busy}, 0);
        chk("zero_req_n", {31'd0, req_n}, 1);
        tick();
        chk("zero_done_off", {31'd0, done}, 0);
        chk("zero_busy_off", {31'd0, busy}, 0);
        chk("zero_req_n_off", {31'd0, req_n}, 1);

        // Start with count 9 during first gap of a 2-pulse burst.
        run_burst(2, LOWC + 1);

        // Back-to-back: start right after done.
        run_burst(1, -1);

        // Maximum count.
        run_burst(255, -1);

        // Reset in the third cycle of the second low phase.
        start = 1'b1;
        count = 8'd3;
        tick();
        start = 1'b0;
        count = 8'd0;
        for (int i = 0; i < PER + 2; i++) tick();
        chk("mr_pre_req_n", {31'd0, req_n}, 0);
        chk("mr_pre_remaining", {24'd0, remaining}, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_req_n", {31'd0, req_n}, 1);
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_done", {31'd0, done}, 0);
        chk("mr_remaining", {24'd0, remaining}, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mr_no_done", {31'd0, done}, 0);
            chk("mr_idle_req_n", {31'd0, req_n}, 1);
        end

`ifdef PULSE_BURST_ABORT_EN
        // Abort in the first gap of a 5-pulse burst.
        start = 1'b1;
        count = 8'd5;
        tick();
        start = 1'b0;
        count = 8'd0;
        for (int i = 0; i < LOWC + 1; i++) tick();
        chk("ab_pre_req_n", {31'd0, req_n}, 1);
        chk("ab_pre_busy", {31'd0, busy}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done", {31'd0, done}, 1);
        chk("ab_busy", {31'd0, busy}, 0);
        chk("ab_remaining", {24'd0, remaining}, 4);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ab_after_req_n", {31'd0, req_n}, 1);
            chk("ab_after_done", {31'd0, done}, 0);
            chk("ab_after_rem", {24'd0, remaining}, 4);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Upstream request generator for the executor's strobe pulse maker. On a start command it drives the pulse maker's active-low request input through a burst of N request phases. Each phase is a fixed-length low period followed by a fixed high gap, so the pulse maker emits exactly N full-width low strobes. It reports busy, a remaining-pulse count, and a one-cycle done.

## Interface
- CNT_W, 8: width of burst count and remaining count
- LOW_CYCLES, 6: clock periods `req_n` is held low per phase; must be ≥ 6 so the pulse maker completes its full countdown
- GAP_CYCLES, 4: clock periods `req_n` is held high between phases; must be ≥ 1 so the pulse maker re-arms
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle burst command; sampled only in IDLE
- count  in  CNT_W  number of pulses; sampled with `start`
- req_n  out  1  active-low request to the pulse maker's `in`
- busy  out  1  high while a burst is in LOW or GAP
- done  out  1  one-cycle completion strobe
- remaining  out  CNT_W  pulses not yet issued

## Operation
- All outputs are registered. Reset values: `req_n`=1, `busy`=0, `done`=0, `remaining`=0, state IDLE.
- The state machine has four states: IDLE, LOW, GAP, DONE.
- **IDLE:**
  - `start`=1 and `count`≠0: load `remaining`=`count`, load the phase timer with LOW_CYCLES, go to LOW.
  - `start`=1 and `count`=0: go to DONE without issuing any request.
- **LOW:** `req_n`=0, `busy`=1. When the phase timer expires:
  - decrement `remaining`;
  - if the new `remaining` is 0, go to DONE;
  - otherwise load GAP_CYCLES and go to GAP.
- **GAP:** `req_n`=1, `busy`=1. When the phase timer expires, load LOW_CYCLES and go to LOW.
- **DONE:** `done`=1, `busy`=0, `req_n`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; `count` is not re-sampled.
- Arithmetic rules:
  - `remaining` never wraps: the decrement occurs only when `remaining` ≥ 1.
  - The maximum count (2^CNT_W − 1) is a legal burst.
- Reset low mid-burst: at the next edge all outputs return to their reset values and no `done` is produced.

## Timing
- `start` sampled at edge k: `req_n`=0 and `busy`=1 from edge k.
- `req_n` stays low for exactly LOW_CYCLES periods and high for exactly GAP_CYCLES periods between phases.
- Busy duration: N·LOW_CYCLES + (N−1)·GAP_CYCLES periods.
- `remaining` decrements at the same edge that ends each low phase.
- The edge ending the last low phase raises `req_n` and sets `done`=1 for one period.
- `count`=0: `done` is high for the period following edge k.
- Earliest next `start`: the cycle after `done`.

## Configuration
- Macro: `PULSE_BURST_ABORT_EN`.
- **Defined:** adds input port `abort` (1 bit).
  - `abort`=1 in LOW or GAP: at the next edge `req_n`=1, state goes to DONE, and `done` pulses.
  - `remaining` holds its value; nonzero after `done` indicates an aborted burst.
  - `abort` in IDLE or DONE has no effect. `abort` and `start` together in IDLE: `start` wins.
- **Undefined:** no `abort` port; every burst runs to completion or reset.

## Structure
- Shared package `pulse_burst_pkg` holds:
  - the state enum (IDLE, LOW, GAP, DONE);
  - `MIN_LOW_CYCLES`=6 and `MIN_GAP_CYCLES`=1, used for elaboration-time parameter checks;
  - the default parameter constants.
- One sub-module, `phase_timer`: a loadable down-counter sized to max(LOW_CYCLES, GAP_CYCLES), with synchronous active-low reset and a registered `expired` flag.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → `req_n`=1, `busy`=0, `done`=0, `remaining`=0 throughout.
- Burst of 3 (default parameters), `count`=3:
  - `req_n` pattern: low 6, high 4, low 6, high 4, low 6.
  - `busy` high for 26 cycles; `remaining` steps 3→2→1→0; one `done` cycle.
  - With the pulse maker attached, its output shows three low strobes of 3 cycles each.
- Zero count: `count`=0 with `start` → `done` high 1 cycle after start; `req_n` never low; `busy` never high.
- Start while busy: `start` with `count`=9 during the first GAP of a 2-pulse burst → still exactly 2 phases; `remaining` never reloads.
- Mid-burst reset: `reset`=0 in the third cycle of the second LOW phase → `req_n`=1 and `busy`=0 after the next edge; no `done`.
- Abort (macro defined): `count`=5, `abort` in the first GAP → `done` the next cycle, `remaining`=4, no further `req_n` low.
